// File: rtl/uart_tx_fifo_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_if
// Brief    : Push handshake, FIFO status and serial line of the UART TX FIFO.
// Revision : 1.0
// ============================================================================
interface uart_tx_fifo_if #(
    parameter int DEPTH = 16
) ();
    localparam int c_AW = $clog2(DEPTH);

    logic [7:0]    i_push_data;
    logic          i_push_valid;
    logic          o_ready;
    logic          o_full;
    logic          o_empty;
    logic [c_AW:0] o_count;
    logic          o_drop;
    logic          o_tx;
    logic          o_busy;

    modport master (
        output i_push_data, i_push_valid,
        input  o_ready, o_full, o_empty, o_count, o_drop, o_tx, o_busy
    );

    modport slave (
        input  i_push_data, i_push_valid,
        output o_ready, o_full, o_empty, o_count, o_drop, o_tx, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Byte FIFO feeding an 8N1 LSB-first UART transmitter.
// Revision : 1.0
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int DEPTH    = 16
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    uart_tx_fifo_if.slave bus
);
    localparam int c_BIT_DIV = CLK_FREQ / BAUD;
    localparam int c_AW      = $clog2(DEPTH);
    localparam int c_CW      = (c_BIT_DIV > 1) ? $clog2(c_BIT_DIV) : 1;

    localparam logic [c_CW-1:0] c_BIT_LAST  = c_CW'(c_BIT_DIV - 1);
    localparam logic [c_AW:0]   c_FULL      = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0]   c_READY_LIM = (c_AW + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_drop;

    state_t          r_state;
    logic [c_CW-1:0] r_bit_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_tx;

    logic            w_full;
    logic            w_empty;
    logic            w_push_ok;
    logic            w_pop;
    logic            w_bit_done;
    logic [c_AW:0]   w_count_nxt;
    state_t          w_state_nxt;
    logic [c_CW-1:0] w_bit_cnt_nxt;
    logic [2:0]      w_bit_idx_nxt;
    logic [7:0]      w_shift_nxt;
    logic            w_tx_nxt;

    assign w_full     = (r_count == c_FULL);
    assign w_empty    = (r_count == '0);
    assign w_push_ok  = bus.i_push_valid && !w_full;
    assign w_bit_done = (r_bit_cnt == c_BIT_LAST);

    assign bus.o_ready = (r_count < c_READY_LIM);
    assign bus.o_full  = w_full;
    assign bus.o_empty = w_empty;
    assign bus.o_count = r_count;
    assign bus.o_drop  = r_drop;
    assign bus.o_tx    = r_tx;
    assign bus.o_busy  = (r_state != S_IDLE);

    // Storage carries no reset; its contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= bus.i_push_data;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_ok, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drop   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_drop  <= bus.i_push_valid && w_full;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Line level is a function of the current state, so o_tx lags the FSM by one register stage.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_pop         = 1'b0;
        w_tx_nxt      = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_shift_nxt   = r_mem[r_rd_ptr];
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = S_START;
                end
            end
            S_START: begin
                w_tx_nxt = 1'b0;
                if (w_bit_done) begin
                    w_bit_cnt_nxt = '0;
                    w_bit_idx_nxt = 3'd0;
                    w_state_nxt   = S_DATA;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                end
            end
            S_DATA: begin
                w_tx_nxt = r_shift[0];
                if (w_bit_done) begin
                    w_bit_cnt_nxt = '0;
                    w_shift_nxt   = {1'b0, r_shift[7:1]};
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                end
            end
            S_STOP: begin
                w_tx_nxt = 1'b1;
                if (w_bit_done) begin
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Scoreboard bench for uart_tx_fifo; a line decoder checks each frame.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_fifo;
    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int DEPTH    = 4;
    localparam int BIT_DIV  = CLK_FREQ / BAUD;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_rx     = 0;
    bit   mon_en   = 1'b1;

    logic [7:0] exp_q [$];
    int         fall_q [$];

    uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_fifo #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder: samples the middle of every bit and scores the byte against exp_q.
    initial begin
        logic       tx_prev;
        logic [7:0] rx;
        logic [7:0] want;
        tx_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && tx_prev && !bus.o_tx) begin
                fall_q.push_back(cyc);
                repeat (BIT_DIV / 2) @(negedge clk);
                n_checks++;
                if (bus.o_tx !== 1'b0) begin
                    n_fail++;
                    $display("FAIL start_bit: line=%b required=0", bus.o_tx);
                end
                for (int b = 0; b < 8; b++) begin
                    repeat (BIT_DIV) @(negedge clk);
                    rx[b] = bus.o_tx;
                end
                repeat (BIT_DIV) @(negedge clk);
                n_checks++;
                if (bus.o_tx !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stop_bit: line=%b required=1", bus.o_tx);
                end
                n_rx++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL frame_byte: got %h with nothing outstanding", rx);
                end else begin
                    want = exp_q.pop_front();
                    if (rx !== want) begin
                        n_fail++;
                        $display("FAIL frame_byte: got %h required %h", rx, want);
                    end
                end
            end
            tx_prev = bus.o_tx;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_drain(input int budget, output bit ok);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.o_busy || !bus.o_empty) && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (n < budget);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.o_tx, bus.o_empty, bus.o_ready, bus.o_busy, bus.o_full, bus.o_drop} !== 6'b111000) begin
            n_fail++;
            $display("FAIL reset_flags: tx/empty/ready/busy/full/drop=%b required 111000",
                     {bus.o_tx, bus.o_empty, bus.o_ready, bus.o_busy, bus.o_full, bus.o_drop});
        end
        n_checks++;
        if (bus.o_count !== '0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d required 0", bus.o_count);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.o_tx !== 1'b1 || bus.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: tx=%b busy=%b required tx=1 busy=0", bus.o_tx, bus.o_busy);
        end
    endtask

    task automatic test_single();
        int n;
        bit ok;
        exp_q.push_back(8'h41);
        bus.i_push_data  = 8'h41;
        bus.i_push_valid = 1'b1;
        @(negedge clk);
        bus.i_push_valid = 1'b0;
        n_checks++;
        if (bus.o_count !== 3'd1 || bus.o_busy !== 1'b0 || bus.o_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL single_after_push: count=%0d busy=%b tx=%b required 1/0/1",
                     bus.o_count, bus.o_busy, bus.o_tx);
        end
        @(negedge clk);
        n_checks++;
        if (bus.o_count !== 3'd0 || bus.o_busy !== 1'b1 || bus.o_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL single_after_pop: count=%0d busy=%b tx=%b required 0/1/1",
                     bus.o_count, bus.o_busy, bus.o_tx);
        end
        n = 0;
        while (bus.o_busy && n < 300) begin
            if (n == 1) begin
                n_checks++;
                if (bus.o_tx !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_tx_latency: tx=%b two edges after push, required 0", bus.o_tx);
                end
            end
            n++;
            @(negedge clk);
        end
        n_checks++;
        if (n != 10 * BIT_DIV) begin
            n_fail++;
            $display("FAIL single_busy_len: busy for %0d cycles required %0d", n, 10 * BIT_DIV);
        end
        n_checks++;
        if (bus.o_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL single_empty: empty=%b required 1", bus.o_empty);
        end
        wait_drain(200, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_drain: timeout with %0d bytes outstanding", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [4];
        int  peak;
        bit  ok;
        bytes = '{8'h33, 8'h2E, 8'h43, 8'h0A};
        fall_q.delete();
        peak = 0;
        for (int i = 0; i < 4; i++) begin
            bus.i_push_data  = bytes[i];
            bus.i_push_valid = 1'b1;
            exp_q.push_back(bytes[i]);
            @(negedge clk);
            if (int'(bus.o_count) > peak) peak = int'(bus.o_count);
            if (i == 2) begin
                n_checks++;
                if (bus.o_count !== 3'd2 || bus.o_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_ready_hi: count=%0d ready=%b required 2/1", bus.o_count, bus.o_ready);
                end
            end
            if (i == 3) begin
                n_checks++;
                if (bus.o_count !== 3'd3 || bus.o_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_ready_lo: count=%0d ready=%b required 3/0", bus.o_count, bus.o_ready);
                end
            end
        end
        bus.i_push_valid = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (int'(bus.o_count) > peak) peak = int'(bus.o_count);
        end
        n_checks++;
        if (peak != 3) begin
            n_fail++;
            $display("FAIL b2b_peak: peak count %0d required 3", peak);
        end
        wait_drain(600, ok);
        n_checks++;
        if (!ok || fall_q.size() != 4) begin
            n_fail++;
            $display("FAIL b2b_frames: %0d frames seen required 4 (drained=%b)", fall_q.size(), ok);
        end
        for (int i = 1; i < fall_q.size(); i++) begin
            n_checks++;
            if (fall_q[i] - fall_q[i-1] != 10 * BIT_DIV + 1) begin
                n_fail++;
                $display("FAIL b2b_spacing: %0d cycles between starts required %0d",
                         fall_q[i] - fall_q[i-1], 10 * BIT_DIV + 1);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] ovf [6];
        int drops;
        bit ok;
        ovf = '{8'h31, 8'h32, 8'h3A, 8'h25, 8'h6D, 8'h09};
        exp_q.push_back(8'h39);
        bus.i_push_data  = 8'h39;
        bus.i_push_valid = 1'b1;
        @(negedge clk);
        bus.i_push_valid = 1'b0;
        repeat (3) @(negedge clk);
        drops = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 6) begin
                bus.i_push_data  = ovf[i];
                bus.i_push_valid = 1'b1;
                if (i < DEPTH) exp_q.push_back(ovf[i]);
            end else begin
                bus.i_push_valid = 1'b0;
            end
            @(negedge clk);
            if (bus.o_drop === 1'b1) drops++;
            if (i == 3) begin
                n_checks++;
                if (bus.o_count !== 3'd4 || bus.o_full !== 1'b1 || bus.o_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ovf_full: count=%0d full=%b ready=%b required 4/1/0",
                             bus.o_count, bus.o_full, bus.o_ready);
                end
            end
        end
        n_checks++;
        if (drops != 2) begin
            n_fail++;
            $display("FAIL ovf_drops: %0d drop pulses required 2", drops);
        end
        wait_drain(800, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ovf_drain: timeout with %0d bytes outstanding", exp_q.size());
        end
    endtask

    task automatic test_wrap();
        int rx0;
        int k;
        bit ok;
        rx0 = n_rx;
        k = 0;
        for (int g = 0; g < 4; g++) begin
            for (int j = 0; j < 3 && k < 10; j++) begin
                bus.i_push_data  = 8'h30 + 8'(k);
                bus.i_push_valid = 1'b1;
                exp_q.push_back(8'h30 + 8'(k));
                k++;
                @(negedge clk);
            end
            bus.i_push_valid = 1'b0;
            wait_drain(500, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL wrap_drain: group %0d timeout, %0d outstanding", g, exp_q.size());
            end
        end
        n_checks++;
        if (n_rx - rx0 != 10) begin
            n_fail++;
            $display("FAIL wrap_count: received %0d frames required 10", n_rx - rx0);
        end
    endtask

    task automatic test_midframe_reset();
        int n;
        int lows;
        mon_en = 1'b0;
        bus.i_push_data  = 8'h55;
        bus.i_push_valid = 1'b1;
        @(negedge clk);
        bus.i_push_valid = 1'b0;
        n = 0;
        while (bus.o_tx !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 20) begin
            n_fail++;
            $display("FAIL mid_start: line never fell, tx=%b required 0", bus.o_tx);
        end
        repeat (5 * BIT_DIV + BIT_DIV / 2) @(negedge clk);
        n_checks++;
        if (bus.o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy: busy=%b inside bit 4, required 1", bus.o_busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.o_tx !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_count !== '0) begin
            n_fail++;
            $display("FAIL mid_async: tx=%b busy=%b count=%0d required 1/0/0",
                     bus.o_tx, bus.o_busy, bus.o_count);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.o_count !== '0 || bus.o_empty !== 1'b1 || bus.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_release: count=%0d empty=%b busy=%b required 0/1/0",
                     bus.o_count, bus.o_empty, bus.o_busy);
        end
        lows = 0;
        repeat (150) begin
            @(negedge clk);
            if (bus.o_tx !== 1'b1 || bus.o_busy !== 1'b0) lows++;
        end
        n_checks++;
        if (lows != 0) begin
            n_fail++;
            $display("FAIL mid_stale: %0d non-idle cycles after release, required 0", lows);
        end
        mon_en = 1'b1;
    endtask

    initial begin
        bus.i_push_data  = 8'h00;
        bus.i_push_valid = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_wrap();
        test_midframe_reset();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: %0d expected bytes never sent, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
